// File: rtl/jpeg_bitstream_packer.sv
// JPEG entropy-coded segment packer: MSB-first bit packing,
// 0xFF/0x00 byte stuffing and 1-bit padding on flush.
module jpeg_bitstream_packer #(
  parameter int CODE_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic [CODE_WIDTH-1:0] code_bits,
  input  logic [4:0]            code_length,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [7:0]            byte_data,
  output logic [5:0]            fill_level
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [5:0] ACC_BITS = 6'(ACC_WIDTH);
  localparam logic [5:0] RDY_MAX  = 6'(ACC_WIDTH - CODE_WIDTH);
  localparam logic [4:0] LEN_MAX  = 5'(CODE_WIDTH);

  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [5:0]            cnt_q, cnt_d;
  logic                  bv_q, bv_d;
  logic [7:0]            bd_q, bd_d;
  logic                  stuff_q, stuff_d;
  logic [1:0]            state_q, state_d;

  logic [4:0]            len;
  logic [CODE_WIDTH-1:0] mask;
  logic [ACC_WIDTH-1:0]  ext;
  logic [5:0]            sh;
  logic                  out_free;
  logic [7:0]            top;

  always_comb begin
    len  = (code_length > LEN_MAX) ? LEN_MAX
                                   : code_length;
    mask = ~({CODE_WIDTH{1'b1}} << len);
    ext  = ACC_WIDTH'(code_bits & mask);
    top  = acc_q[ACC_WIDTH-1 -: 8];

    code_ready = (state_q == S_RUN) &&
                 (cnt_q <= RDY_MAX);
    out_free   = !bv_q || byte_ready;
    flush_done = 1'b0;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bv_d    = bv_q && !byte_ready;
    bd_d    = bd_q;
    stuff_d = stuff_q;
    state_d = state_q;
    sh      = '0;

    // a pending stuff byte always wins so 0x00 trails 0xFF
    if (out_free) begin
      if (stuff_q) begin
        bv_d    = 1'b1;
        bd_d    = 8'h00;
        stuff_d = 1'b0;
      end else if (cnt_q >= 6'd8) begin
        bv_d    = 1'b1;
        bd_d    = top;
        acc_d   = acc_q << 8;
        cnt_d   = cnt_q - 6'd8;
        stuff_d = (top == 8'hFF);
      end
    end

    // append after the byte load so offset uses updated count
    if (code_valid && code_ready && len != 5'd0) begin
      sh    = ACC_BITS - cnt_d - {1'b0, len};
      acc_d = acc_d | (ext << sh);
      cnt_d = cnt_d + {1'b0, len};
    end

    unique case (1'b1)
      state_q == S_RUN: begin
        if (flush && code_ready)
          state_d = S_DRAIN;
      end
      state_q == S_DRAIN: begin
        if (cnt_q == 6'd0) begin
          state_d = S_WAIT;
        end else if (cnt_q < 6'd8) begin
          acc_d[ACC_WIDTH-1 -: 8] =
            top | (8'hFF >> cnt_q[2:0]);
          cnt_d = 6'd8;
        end
      end
      state_q == S_WAIT: begin
        if (!stuff_q && out_free) begin
          flush_done = 1'b1;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      bv_q    <= 1'b0;
      bd_q    <= 8'h00;
      stuff_q <= 1'b0;
      state_q <= S_RUN;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bv_q    <= bv_d;
      bd_q    <= bd_d;
      stuff_q <= stuff_d;
      state_q <= state_d;
    end
  end

  assign byte_valid = bv_q;
  assign byte_data  = bd_q;
  assign fill_level = cnt_q;

endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: bit-queue reference model,
// directed cases from the block description plus random traffic.
module tb_jpeg_bitstream_packer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        code_valid = 1'b0;
  logic        flush = 1'b0;
  logic        byte_ready = 1'b0;
  logic [15:0] code_bits = '0;
  logic [4:0]  code_length = '0;
  logic        code_ready;
  logic        flush_done;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [5:0]  fill_level;

  jpeg_bitstream_packer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .code_bits   (code_bits),
    .code_length (code_length),
    .flush       (flush),
    .flush_done  (flush_done),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .byte_data   (byte_data),
    .fill_level  (fill_level)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int xfer_cyc = -1;
  int done_cyc = -1;
  int flacc_cyc = -1;
  bit fl_pend = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  bit         bq[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  // Model: bits are a plain FIFO, bytes cut every 8 bits.
  task automatic form();
    while (bq.size() >= 8) begin
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
        v = {v[6:0], bq.pop_front()};
      exp_q.push_back(v);
      if (v == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic push_code(input logic [15:0] b,
                           input logic [4:0] l);
    int n;
    n = (l > 5'd16) ? 16 : int'(l);
    for (int i = n - 1; i >= 0; i--)
      bq.push_back(b[i]);
    form();
  endtask

  task automatic pad();
    if (bq.size() > 0) begin
      while (bq.size() < 8) bq.push_back(1'b1);
      form();
    end
  endtask

  function automatic logic [31:0] gw();
    logic [31:0] w;
    w = '0;
    foreach (got[i]) w = {w[23:0], got[i]};
    return w;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", byte_valid, 1);
        chk("hold_data", byte_data, prev_data);
      end
      if (byte_valid && byte_ready) begin
        got.push_back(byte_data);
        xfer_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL extra_byte: got %02h want none",
                   byte_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (byte_data !== e) begin
            n_bad++;
            $display("FAIL byte: got %02h want %02h",
                     byte_data, e);
          end
        end
      end
      if (flush_done) begin
        n_done++;
        done_cyc = cyc;
        chk("done_pending", fl_pend, 1);
        chk("done_drained", exp_q.size(), 0);
        chk("done_fill", fill_level, 0);
        fl_pend = 1'b0;
      end
      chk("ready_limit",
          code_ready && fill_level > 6'd16, 0);
      chk("fill_max", fill_level > 6'd32, 0);
      if (code_valid && code_ready) begin
        n_acc++;
        push_code(code_bits, code_length);
      end
      if (flush && code_ready) begin
        pad();
        fl_pend = 1'b1;
        flacc_cyc = cyc;
      end
      prev_stall = byte_valid && !byte_ready;
      prev_data = byte_data;
    end
  end

  // Called and returns at posedge+1.
  task automatic send(input logic [15:0] b,
                      input logic [4:0] l,
                      input logic v,
                      input logic f);
    int k;
    k = 0;
    code_bits = b;
    code_length = l;
    code_valid = v;
    flush = f;
    do begin
      @(negedge clock);
      k++;
    end while (!code_ready && k < 300);
    if (!code_ready) chk("send_timeout", code_ready, 1);
    @(posedge clock);
    #1;
    code_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (fl_pend && k < 300) begin
      @(posedge clock);
      k++;
    end
    @(posedge clock);
    #1;
    if (fl_pend) chk("done_timeout", fl_pend, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int k;
    int mode;
    #1;
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_done", flush_done, 0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    chk("rst_ready", code_ready, 1);
    byte_ready = 1'b1;

    got.delete();
    send(16'h0005, 5'd3, 1'b1, 1'b0);
    send(16'h001F, 5'd5, 1'b1, 1'b0);
    idle(4);
    chk("t1_count", got.size(), 1);
    chk("t1_byte", gw(), 32'hBF);
    chk("t1_fill", fill_level, 0);

    got.delete();
    send(16'hFF00, 5'd16, 1'b1, 1'b0);
    idle(5);
    chk("t2_count", got.size(), 3);
    chk("t2_bytes", gw(), 32'hFF0000);

    got.delete();
    n_done = 0;
    send(16'h0002, 5'd3, 1'b1, 1'b0);
    send(16'h0000, 5'd0, 1'b0, 1'b1);
    wait_done();
    chk("t3_count", got.size(), 1);
    chk("t3_byte", gw(), 32'h5F);
    chk("t3_done_gap", done_cyc - xfer_cyc, 1);
    idle(3);
    chk("t3_one_pulse", n_done, 1);

    got.delete();
    send(16'h0000, 5'd0, 1'b0, 1'b1);
    wait_done();
    chk("empty_gap", done_cyc - flacc_cyc, 2);
    chk("empty_count", got.size(), 0);

    got.delete();
    byte_ready = 1'b0;
    n_acc = 0;
    code_bits = 16'hA5C3;
    code_length = 5'd16;
    code_valid = 1'b1;
    repeat (30) begin
      @(posedge clock);
      #1;
    end
    chk("t4_accepts", n_acc, 2);
    chk("t4_fill", fill_level, 24);
    chk("t4_ready", code_ready, 0);
    chk("t4_valid", byte_valid, 1);
    chk("t4_data", byte_data, 8'hA5);
    byte_ready = 1'b1;
    k = 0;
    while (n_acc < 10 && k < 300) begin
      @(posedge clock);
      #1;
      k++;
    end
    code_valid = 1'b0;
    idle(20);
    chk("t4_count", got.size(), 20);
    foreach (got[i])
      chk("t4_pattern", got[i],
          (i % 2 == 1) ? 8'hC3 : 8'hA5);

    got.delete();
    send(16'h0005, 5'd3, 1'b1, 1'b0);
    idle(2);
    chk("t5_fill3", fill_level, 3);
    send(16'hFFFF, 5'd0, 1'b1, 1'b0);
    idle(2);
    chk("t5_len0", fill_level, 3);
    send(16'h1234, 5'd20, 1'b1, 1'b0);
    idle(4);
    chk("t5_count", got.size(), 2);
    chk("t5_bytes", gw(), 32'hA246);
    chk("t5_fill", fill_level, 3);
    chk("t5_model_fill", fill_level, bq.size());
    send(16'h0000, 5'd0, 1'b0, 1'b1);
    wait_done();
    chk("t5_pad_count", got.size(), 3);
    chk("t5_pad", gw(), 32'hA2469F);

    byte_ready = 1'b0;
    send(16'h1234, 5'd16, 1'b1, 1'b0);
    idle(3);
    chk("t6_valid_pre", byte_valid, 1);
    #2;
    reset_n = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("t6_valid_async", byte_valid, 0);
    chk("t6_fill", fill_level, 0);
    bq.delete();
    exp_q.delete();
    fl_pend = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_ready", code_ready, 1);
    chk("t6_valid", byte_valid, 0);
    byte_ready = 1'b1;

    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) mode = int'($urandom_range(0, 2));
      code_valid = ($urandom % 4) != 0;
      code_bits = 16'($urandom);
      code_length = 5'($urandom_range(0, 20));
      flush = ($urandom % 50) == 0;
      case (mode)
        0: byte_ready = 1'b1;
        1: byte_ready = ($urandom % 3) != 0;
        default: byte_ready = ($urandom % 5) == 0;
      endcase
      @(posedge clock);
      #1;
    end
    code_valid = 1'b0;
    flush = 1'b0;
    byte_ready = 1'b1;
    if (fl_pend) wait_done();
    send(16'h0000, 5'd0, 1'b0, 1'b1);
    wait_done();
    idle(3);
    chk("end_exp_empty", exp_q.size(), 0);
    chk("end_bits_empty", bq.size(), 0);
    chk("end_fill", fill_level, 0);
    chk("end_valid", byte_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
